multi_core_mem_arbiter: RTL and testbench

Parametrised successor to the single-core memory selector. It shares one data-memory port among NUM_CORES processor cores and the external communication port. While status selects run mode, cores win memory through round-robin arbitration with a req/ack handshake. Otherwise the com port owns memory outright. It sits between the core array, the com interface and the data-memory instance in the multi-core top.

---
 rtl/multi_core_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_multi_core_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_core_mem_arbiter.sv
// Shares one data-memory port between NUM_CORES cores (round-robin req/ack) and the com port.
// Optional macro ARB_STATS_EN adds a saturating stall_count output.
module multi_core_mem_arbiter #(
  parameter int         NUM_CORES  = 4,
  parameter int         DATA_W     = 16,
  parameter int         ADDR_W     = 16,
  parameter logic [1:0] RUN_STATUS = 2'b01
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  status,
  input  logic [DATA_W-1:0]           com_data_in,
  input  logic [ADDR_W-1:0]           com_addr,
  input  logic                        com_wr_en,
  output logic [DATA_W-1:0]           com_data_out,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           DM_addr,
  output logic [DATA_W-1:0]           DM_data_in,
  output logic                        DM_write_en,
  input  logic [DATA_W-1:0]           DM_out
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]                 stall_count
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IDX_W:0]   NC   = (IDX_W+1)'(NUM_CORES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     rr_ptr, ptr_nxt, pick, gnt_p1;
  logic [IDX_W:0]       sum;
  logic                 run, pick_vld, pick_we, grant_now, ptr_ld, rdata_ld;
  logic [NUM_CORES-1:0] elig, ack_nxt;
  logic [ADDR_W-1:0]    pick_addr, addr_p1;
  logic [DATA_W-1:0]    pick_wdata, wdata_p1;

  assign run = (status == RUN_STATUS);

  // The core just acked still holds req for one cycle; keep it out of the search.
  assign elig = core_req & ~core_ack;

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    sum      = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= NC) sum = sum - NC;
      if (!pick_vld && elig[sum[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = sum[IDX_W-1:0];
      end
    end
  end

  assign pick_addr  = core_addr[int'(pick)*ADDR_W +: ADDR_W];
  assign pick_wdata = core_wdata[int'(pick)*DATA_W +: DATA_W];
  assign pick_we    = core_we[pick];
  assign ptr_nxt    = (gnt_p1 == LAST) ? '0 : gnt_p1 + IDX_W'(1);

  always_comb begin
    state_nxt = state;
    grant_now = 1'b0;
    ack_nxt   = '0;
    ptr_ld    = 1'b0;
    rdata_ld  = 1'b0;
    case (state)
      IDLE: begin
        if (run && pick_vld) begin
          grant_now = 1'b1;
          state_nxt = pick_we ? WRITE : READ_WAIT;
        end
      end
      WRITE: begin
        // The write reached memory at grant, so it is acked even if status has left run mode.
        ack_nxt[gnt_p1] = 1'b1;
        ptr_ld          = 1'b1;
        state_nxt       = IDLE;
      end
      READ_WAIT: begin
        if (run) begin
          ack_nxt[gnt_p1] = 1'b1;
          rdata_ld        = 1'b1;
          ptr_ld          = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    DM_addr     = addr_p1;
    DM_data_in  = wdata_p1;
    DM_write_en = 1'b0;
    if (rst) begin
      DM_addr    = '0;
      DM_data_in = '0;
    end else if (!run) begin
      DM_addr     = com_addr;
      DM_data_in  = com_data_in;
      DM_write_en = com_wr_en;
    end else if (grant_now) begin
      DM_addr     = pick_addr;
      DM_data_in  = pick_wdata;
      DM_write_en = pick_we;
    end
  end

  // Stage p0 -> p1: control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      core_ack     <= '0;
      core_rdata   <= '0;
      com_data_out <= '0;
    end else begin
      state        <= state_nxt;
      core_ack     <= ack_nxt;
      com_data_out <= DM_out;
      if (rdata_ld) core_rdata <= DM_out;
      if (ptr_ld)   rr_ptr     <= ptr_nxt;
    end
  end

  // Stage p0 -> p1: granted access captured so input changes cannot disturb it
  always_ff @(posedge clk) begin
    if (grant_now) begin
      gnt_p1   <= pick;
      addr_p1  <= pick_addr;
      wdata_p1 <= pick_wdata;
    end
  end

`ifdef ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [NUM_CORES-1:0] busy_mask;
  logic                 stall_now;

  always_comb begin
    busy_mask = '0;
    if (state != IDLE)  busy_mask[gnt_p1] = 1'b1;
    else if (grant_now) busy_mask[pick]   = 1'b1;
    stall_now = run && (|(core_req & ~core_ack & ~busy_mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            stall_count <= '0;
    else if (stall_now) stall_count <= sat_inc(stall_count);
  end
`endif

endmodule

// File: tb/tb_multi_core_mem_arbiter.sv
// Table-driven bench for multi_core_mem_arbiter with a behavioural synchronous data memory.
module tb_multi_core_mem_arbiter;

  localparam int N = -1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  status;
  logic [15:0] com_data_in, com_addr, com_data_out;
  logic        com_wr_en;
  logic [3:0]  core_req, core_we, core_ack;
  logic [63:0] core_addr, core_wdata;
  logic [15:0] core_rdata, DM_addr, DM_data_in, DM_out;
  logic        DM_write_en;
`ifdef ARB_STATS_EN
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  multi_core_mem_arbiter dut (
    .clk(clk), .rst(rst), .status(status),
    .com_data_in(com_data_in), .com_addr(com_addr), .com_wr_en(com_wr_en),
    .com_data_out(com_data_out),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata),
    .DM_addr(DM_addr), .DM_data_in(DM_data_in), .DM_write_en(DM_write_en), .DM_out(DM_out)
`ifdef ARB_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (DM_write_en) mem[DM_addr[7:0]] <= DM_data_in;
    DM_out <= mem[DM_addr[7:0]];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int rst, st, caddr, cdata, cwe, req, we, wdata;
    int ack, dwe, daddr, rdata, cout;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(int r, int st, int caddr, int cdata, int cwe,
                                  int req, int we, int wdata,
                                  int ack, int dwe, int daddr, int rdata, int cout);
    vec_t e;
    e.rst = r; e.st = st; e.caddr = caddr; e.cdata = cdata; e.cwe = cwe;
    e.req = req; e.we = we; e.wdata = wdata;
    e.ack = ack; e.dwe = dwe; e.daddr = daddr; e.rdata = rdata; e.cout = cout;
    vecs.push_back(e);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; status = 2'b00;
    com_data_in = '0; com_addr = '0; com_wr_en = 1'b0;
    core_req = '0; core_we = '0; core_wdata = '0;
    core_addr = {16'h0030, 16'h0020, 16'h0010, 16'h0000};

    // rst st caddr  cdata   cwe req     we      wdata    ack     dwe daddr  rdata    cout
    add_vec(1, 0, 'h00, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, 'h00, 'h0000, 'h0000);
    add_vec(0, 0, 'h10, 'hBEEF, 1, 'b0000, 'b0000, 'h0000, 'b0000, 1, 'h10, N,       N);
    add_vec(0, 0, 'h00, 'hA000, 1, 'b0000, 'b0000, 'h0000, 'b0000, 1, 'h00, N,       N);
    add_vec(0, 0, 'h30, 'hD003, 1, 'b0000, 'b0000, 'h0000, 'b0000, 1, 'h30, N,       N);
    add_vec(0, 0, 'h10, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, 'h10, 'h0000, N);
    add_vec(0, 0, 'h10, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, 'h10, 'h0000, N);
    add_vec(0, 0, 'h10, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, 'h10, 'h0000, 'hBEEF);
    // core 2 write then read
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0100, 'h1234, 'b0000, 1, 'h20, N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0100, 'h1234, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0100, 'h1234, 'b0100, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0000, 'h0000, 'b0000, 0, 'h20, N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0000, 'h0000, 'b0100, 0, N,    'h1234, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, N,    'h1234, N);
    // core 3 read moves the pointer to 0
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1000, 'b0000, 'h0000, 'b0000, 0, 'h30, N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1000, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1000, 'b0000, 'h0000, 'b1000, 0, N,    'hD003, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    // four-way contention, core 0 re-requests back to back
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1111, 'b0000, 'h0000, 'b0000, 0, 'h00, N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1111, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1111, 'b0000, 'h0000, 'b0001, 0, 'h10, 'hA000, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1111, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1111, 'b0000, 'h0000, 'b0010, 0, 'h20, 'hBEEF, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1101, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1101, 'b0000, 'h0000, 'b0100, 0, 'h30, 'h1234, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1001, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1001, 'b0000, 'h0000, 'b1000, 0, 'h00, 'hD003, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0001, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0001, 'b0000, 'h0000, 'b0001, 0, N,    'hA000, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    // core 2 moves pointer to 3; then cores 1 and 3 -> 3 first, 1 after wrap
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0000, 'h0000, 'b0000, 0, 'h20, N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0000, 'h0000, 'b0100, 0, N,    'h1234, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1010, 'b0000, 'h0000, 'b0000, 0, 'h30, N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1010, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b1010, 'b0000, 'h0000, 'b1000, 0, 'h10, 'hD003, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0010, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0010, 'b0000, 'h0000, 'b0010, 0, N,    'hBEEF, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    // read abandoned by a status change, then served after return to run mode
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0001, 'b0000, 'h0000, 'b0000, 0, 'h00, N,       N);
    add_vec(0, 2, 'h10, 'h0000, 0, 'b0001, 'b0000, 'h0000, 'b0000, 0, 'h10, N,       N);
    add_vec(0, 2, 'h10, 'h0000, 0, 'b0001, 'b0000, 'h0000, 'b0000, 0, 'h10, 'hBEEF, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0001, 'b0000, 'h0000, 'b0000, 0, 'h00, N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0001, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0001, 'b0000, 'h0000, 'b0001, 0, N,    'hA000, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);
    // write in flight when status leaves run mode: still acked and committed
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0010, 'b0010, 'h5555, 'b0000, 1, 'h10, N,       N);
    add_vec(0, 0, 'h00, 'h0000, 0, 'b0010, 'b0010, 'h5555, 'b0000, 0, 'h00, N,       N);
    add_vec(0, 0, 'h00, 'h0000, 0, 'b0010, 'b0010, 'h5555, 'b0010, 0, 'h00, N,       N);
    add_vec(0, 0, 'h10, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, 'h10, N,       N);
    add_vec(0, 0, 'h10, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, 'h10, N,       N);
    add_vec(0, 0, 'h10, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, 'h10, N,       'h5555);
    // reset in the middle of READ_WAIT
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0000, 'h0000, 'b0000, 0, 'h20, N,       N);
    add_vec(1, 1, 'h00, 'h0000, 0, 'b0100, 'b0000, 'h0000, 'b0000, 0, 'h00, 'h0000, 'h0000);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0000, 'h0000, 'b0000, 0, 'h20, 'h0000, 'h0000);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0000, 'h0000, 'b0000, 0, N,    'h0000, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0100, 'b0000, 'h0000, 'b0100, 0, N,    'h1234, N);
    add_vec(0, 1, 'h00, 'h0000, 0, 'b0000, 'b0000, 'h0000, 'b0000, 0, N,    N,       N);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst         = 1'(vecs[i].rst);
      status      = 2'(vecs[i].st);
      com_addr    = 16'(vecs[i].caddr);
      com_data_in = 16'(vecs[i].cdata);
      com_wr_en   = 1'(vecs[i].cwe);
      core_req    = 4'(vecs[i].req);
      core_we     = 4'(vecs[i].we);
      core_wdata  = {4{16'(vecs[i].wdata)}};
      #1;
      chk("core_ack", i, 32'(core_ack), 32'(vecs[i].ack));
      chk("dm_write_en", i, 32'(DM_write_en), 32'(vecs[i].dwe));
      if (vecs[i].daddr >= 0) chk("dm_addr", i, 32'(DM_addr), 32'(vecs[i].daddr));
      if (vecs[i].rdata >= 0) chk("core_rdata", i, 32'(core_rdata), 32'(vecs[i].rdata));
      if (vecs[i].cout >= 0)  chk("com_data_out", i, 32'(com_data_out), 32'(vecs[i].cout));
    end

`ifdef ARB_STATS_EN
    begin
      logic [3:0] pending;
      @(negedge clk);
      rst = 1'b1; status = 2'b01; core_req = '0; core_we = '0;
      #1;
      chk("stall_reset", 100, stall_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pending = 4'b1111;
      for (int c = 0; c < 40 && pending != 4'b0000; c++) begin
        @(negedge clk);
        core_req = pending;
        #1;
        pending = pending & ~core_ack;
      end
      if (pending != 4'b0000) begin
        errors++;
        $display("FAIL stall_contention_timeout: pending %b required 0000", pending);
      end
      @(negedge clk);
      core_req = '0;
      #1;
      chk("stall_count_4way", 101, stall_count, 32'd6);
      @(negedge clk);
      core_req = 4'b0001;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("stall_mid_read_reset", 102, stall_count, 32'd0);
      chk("ack_mid_read_reset", 102, 32'(core_ack), 32'd0);
      @(negedge clk);
      rst = 1'b0; core_req = '0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
